// File: rtl/gba_bus_pkg.sv
// rtl/gba_bus_pkg.sv - shared constants and state encoding for the GBA cartridge ROM-bus responder
// The WRITE state exists only when GBA_CART_WRITE_EN is defined.
package gba_bus_pkg;

  localparam int GBA_ADDR_W      = 24;
  localparam int GBA_DATA_W      = 16;
  localparam int GBA_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_READY,
    ST_DRIVE
`ifdef GBA_CART_WRITE_EN
    ,
    ST_WRITE
`endif
  } gba_state_e;

endpackage

// File: rtl/bus_sync.sv
// rtl/bus_sync.sv - N-stage synchronizer for one async strobe, with fall/rise pulses
module bus_sync #(
  parameter int   N         = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic sync_out,
  output logic fall,
  output logic rise
);

  logic [N-1:0] chain_q, chain_d;
  logic         prev_q, prev_d;

  // shift the pin into the chain; remember the last synchronized level for edge detection
  always_comb begin
    chain_d = {chain_q[N-2:0], d_in};
    prev_d  = chain_q[N-1];
  end

  // strobes idle high, so reset to the idle level to avoid a false edge after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {N{RESET_VAL}};
      prev_q  <= RESET_VAL;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign sync_out = chain_q[N-1];
  assign fall     = prev_q & ~sync_out;
  assign rise     = ~prev_q & sync_out;

endmodule

// File: rtl/gba_cart_responder.sv
// rtl/gba_cart_responder.sv - GBA cartridge ROM-bus responder with prefetching read path (writes via GBA_CART_WRITE_EN)
module gba_cart_responder
  import gba_bus_pkg::*;
#(
  parameter int SYNC_STAGES = GBA_SYNC_STAGES,
  parameter int ADDR_W      = GBA_ADDR_W
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  CS_N,
  input  logic                  RD_N,
  input  logic                  WR_N,
  input  logic [GBA_DATA_W-1:0] AD_in,
  input  logic [ADDR_W-17:0]    A_HI,
  output logic [GBA_DATA_W-1:0] AD_out,
  output logic                  AD_oe,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_req,
  input  logic                  mem_ack,
  input  logic [GBA_DATA_W-1:0] mem_rdata,
  output logic                  underrun
`ifdef GBA_CART_WRITE_EN
  ,
  output logic                  mem_we,
  output logic [GBA_DATA_W-1:0] mem_wdata
`endif
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  gba_state_e              state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [GBA_DATA_W-1:0]   buf_q, buf_d;
  logic [GBA_DATA_W-1:0]   ad_out_q, ad_out_d;
  logic                    ad_oe_q, ad_oe_d;
  logic                    mem_req_q, mem_req_d;
  logic                    underrun_q, underrun_d;
  // early: RD fell before the fetch returned, stale buffer is on the pins
  logic                    early_q, early_d;
  // discard: the outstanding request belongs to an abandoned read
  logic                    discard_q, discard_d;
  logic                    ack;

  logic cs_fall, cs_rise, rd_fall, rd_rise;
  logic unused_cs_level, unused_rd_level;

  bus_sync #(.N(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
    .clk(CLK), .rst_n(RST_N), .d_in(CS_N),
    .sync_out(unused_cs_level), .fall(cs_fall), .rise(cs_rise)
  );

  bus_sync #(.N(SYNC_STAGES), .RESET_VAL(1'b1)) u_rd_sync (
    .clk(CLK), .rst_n(RST_N), .d_in(RD_N),
    .sync_out(unused_rd_level), .fall(rd_fall), .rise(rd_rise)
  );

`ifdef GBA_CART_WRITE_EN
  logic                  wr_level, wr_fall, wr_rise;
  logic                  mem_we_q, mem_we_d;
  logic [GBA_DATA_W-1:0] wdata_q, wdata_d;
  logic [GBA_DATA_W-1:0] wcap_q, wcap_d;

  bus_sync #(.N(SYNC_STAGES), .RESET_VAL(1'b1)) u_wr_sync (
    .clk(CLK), .rst_n(RST_N), .d_in(WR_N),
    .sync_out(wr_level), .fall(wr_fall), .rise(wr_rise)
  );
`else
  logic unused_wr_n;
  assign unused_wr_n = WR_N;
`endif

  // an ack only counts while a request is actually outstanding
  assign ack = mem_req_q & mem_ack;

  // state register
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // next-state logic; CS release overrides everything
  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (cs_fall) state_d = ST_FETCH;
        ST_FETCH: begin
          if (ack && !discard_q && !(early_q && rd_rise))
            state_d = (early_q || rd_fall) ? ST_DRIVE : ST_READY;
        end
        ST_READY: begin
          if (rd_fall) state_d = ST_DRIVE;
`ifdef GBA_CART_WRITE_EN
          else if (wr_rise) state_d = ST_WRITE;
`endif
        end
        ST_DRIVE: if (rd_rise) state_d = ST_FETCH;
`ifdef GBA_CART_WRITE_EN
        ST_WRITE: if (ack) state_d = ST_FETCH;
`endif
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // output and datapath next values
  always_comb begin
    addr_d     = addr_q;
    buf_d      = buf_q;
    ad_out_d   = ad_out_q;
    ad_oe_d    = ad_oe_q;
    mem_addr_d = mem_addr_q;
    mem_req_d  = mem_req_q;
    underrun_d = underrun_q;
    early_d    = early_q;
    discard_d  = discard_q;
`ifdef GBA_CART_WRITE_EN
    mem_we_d   = mem_we_q;
    wdata_d    = wdata_q;
    wcap_d     = wcap_q;
`endif

    if (ack) begin
      mem_req_d = 1'b0;
`ifdef GBA_CART_WRITE_EN
      mem_we_d  = 1'b0;
`endif
    end

    if (cs_rise) begin
      ad_oe_d   = 1'b0;
      early_d   = 1'b0;
      discard_d = mem_req_q & ~mem_ack;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ack) discard_d = 1'b0;
          if (cs_fall) begin
            addr_d = {A_HI, AD_in};
            if (rd_fall) begin
              underrun_d = 1'b1;
              early_d    = 1'b1;
              ad_oe_d    = 1'b1;
              ad_out_d   = buf_q;
            end
          end
        end
        ST_FETCH: begin
          if (early_q && rd_rise) begin
            // host finished an underrun read before data came back: move on, drop the old fetch
            ad_oe_d   = 1'b0;
            early_d   = 1'b0;
            addr_d    = addr_q + ADDR_ONE;
            discard_d = mem_req_q & ~mem_ack;
          end else begin
            if (discard_q) begin
              if (ack) discard_d = 1'b0;
            end else if (!mem_req_q) begin
              mem_req_d  = 1'b1;
              mem_addr_d = addr_q;
            end else if (ack) begin
              buf_d = mem_rdata;
              if (early_q || rd_fall) begin
                ad_oe_d  = 1'b1;
                ad_out_d = mem_rdata;
                early_d  = 1'b0;
              end
            end
            if (rd_fall && !(ack && !discard_q)) begin
              underrun_d = 1'b1;
              early_d    = 1'b1;
              ad_oe_d    = 1'b1;
              ad_out_d   = buf_q;
            end
          end
        end
        ST_READY: begin
          if (rd_fall) begin
            ad_oe_d  = 1'b1;
            ad_out_d = buf_q;
          end
`ifdef GBA_CART_WRITE_EN
          else begin
            if (wr_fall) wcap_d = AD_in;
            if (wr_rise) begin
              wdata_d    = wcap_q;
              mem_we_d   = 1'b1;
              mem_req_d  = 1'b1;
              mem_addr_d = addr_q;
            end
          end
`endif
        end
        ST_DRIVE: begin
          if (rd_rise) begin
            ad_oe_d = 1'b0;
            addr_d  = addr_q + ADDR_ONE;
          end
        end
`ifdef GBA_CART_WRITE_EN
        ST_WRITE: if (ack) addr_d = addr_q + ADDR_ONE;
`endif
        default: ;
      endcase
    end
  end

  // output and datapath registers; async reset pulls AD_oe low immediately
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      addr_q     <= '0;
      buf_q      <= '0;
      ad_out_q   <= '0;
      ad_oe_q    <= 1'b0;
      mem_addr_q <= '0;
      mem_req_q  <= 1'b0;
      underrun_q <= 1'b0;
      early_q    <= 1'b0;
      discard_q  <= 1'b0;
`ifdef GBA_CART_WRITE_EN
      mem_we_q   <= 1'b0;
      wdata_q    <= '0;
      wcap_q     <= '0;
`endif
    end else begin
      addr_q     <= addr_d;
      buf_q      <= buf_d;
      ad_out_q   <= ad_out_d;
      ad_oe_q    <= ad_oe_d;
      mem_addr_q <= mem_addr_d;
      mem_req_q  <= mem_req_d;
      underrun_q <= underrun_d;
      early_q    <= early_d;
      discard_q  <= discard_d;
`ifdef GBA_CART_WRITE_EN
      mem_we_q   <= mem_we_d;
      wdata_q    <= wdata_d;
      wcap_q     <= wcap_d;
`endif
    end
  end

  assign AD_out   = ad_out_q;
  assign mem_addr = mem_addr_q;
  assign mem_req  = mem_req_q;
  assign underrun = underrun_q;
`ifdef GBA_CART_WRITE_EN
  // never fight the host while it is driving write data
  assign AD_oe     = ad_oe_q & wr_level;
  assign mem_we    = mem_we_q;
  assign mem_wdata = wdata_q;
`else
  assign AD_oe = ad_oe_q;
`endif

endmodule

// File: tb/tb_gba_cart_responder.sv
// tb/tb_gba_cart_responder.sv - directed self-checking bench for gba_cart_responder
`timescale 1ns/1ps
module tb_gba_cart_responder;

  logic        CLK   = 1'b0;
  logic        RST_N = 1'b0;
  logic        CS_N  = 1'b1;
  logic        RD_N  = 1'b1;
  logic        WR_N  = 1'b1;
  logic [15:0] AD_in = 16'h0;
  logic [7:0]  A_HI  = 8'h0;
  logic [15:0] AD_out;
  logic        AD_oe;
  logic [23:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        underrun;

  int          n_cmp = 0;
  int          n_err = 0;
  int          mem_lat = 3;
  bit          mem_xor = 1'b0;
  logic [15:0] mem_val = 16'hBEEF;
  logic [15:0] exp_q[$];

  gba_cart_responder dut (
    .CLK(CLK), .RST_N(RST_N), .CS_N(CS_N), .RD_N(RD_N), .WR_N(WR_N),
    .AD_in(AD_in), .A_HI(A_HI), .AD_out(AD_out), .AD_oe(AD_oe),
    .mem_addr(mem_addr), .mem_req(mem_req), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .underrun(underrun)
  );

  always #5 CLK = ~CLK;

  // backing-memory model: answers each request after mem_lat cycles
  initial begin
    logic [23:0] a;
    int          l;
    mem_ack   = 1'b0;
    mem_rdata = 16'h0;
    forever begin
      @(posedge CLK); #2;
      if (mem_req === 1'b1) begin
        a = mem_addr;
        l = mem_lat;
        for (int i = 1; i < l; i++) begin
          @(posedge CLK); #2;
        end
        mem_rdata = mem_xor ? (a[15:0] ^ 16'hA5A5) : mem_val;
        mem_ack   = 1'b1;
        @(posedge CLK); #2;
        mem_ack   = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_oe(input logic v, input string tag);
    int n = 0;
    while (AD_oe !== v && n < 40) begin tick(); n++; end
    check(tag, {31'h0, AD_oe}, {31'h0, v});
  endtask

  task automatic wait_req(input logic v, input string tag);
    int n = 0;
    while (mem_req !== v && n < 60) begin tick(); n++; end
    check(tag, {31'h0, mem_req}, {31'h0, v});
  endtask

  task automatic wait_ack(input string tag);
    int n = 0;
    while (mem_ack !== 1'b1 && n < 60) begin tick(); n++; end
    check(tag, {31'h0, mem_ack}, 32'h1);
  endtask

  task automatic cs_start(input logic [7:0] hi, input logic [15:0] lo);
    A_HI  = hi;
    AD_in = lo;
    CS_N  = 1'b0;
  endtask

  task automatic rd_begin(input string tag, input logic [15:0] exp_data);
    logic [15:0] e;
    exp_q.push_back(exp_data);
    RD_N = 1'b0;
    wait_oe(1'b1, {tag, "_oe_on"});
    e = exp_q.pop_front();
    check({tag, "_data"}, {16'h0, AD_out}, {16'h0, e});
  endtask

  task automatic rd_end(input string tag);
    RD_N = 1'b1;
    wait_oe(1'b0, {tag, "_oe_off"});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ad_out"},   {16'h0, AD_out},  32'h0);
    check({tag, "_ad_oe"},    {31'h0, AD_oe},   32'h0);
    check({tag, "_mem_addr"}, {8'h0, mem_addr}, 32'h0);
    check({tag, "_mem_req"},  {31'h0, mem_req}, 32'h0);
    check({tag, "_underrun"}, {31'h0, underrun}, 32'h0);
  endtask

  initial begin
    logic [15:0] e;
    logic [15:0] a16;

    // reset
    repeat (3) tick();
    check_reset_outputs("rst");
    RST_N = 1'b1;
    repeat (2) tick();

    // single read with fixed data, exact RD-to-AD_oe latency
    cs_start(8'h12, 16'h3456);
    wait_req(1'b1, "t1_req");
    check("t1_addr", {8'h0, mem_addr}, 32'h123456);
    wait_ack("t1_ack");
    check("t1_req_drop", {31'h0, mem_req}, 32'h0);
    repeat (3) tick();
    exp_q.push_back(16'hBEEF);
    RD_N = 1'b0;
    tick(); tick();
    check("t1_oe_not_yet", {31'h0, AD_oe}, 32'h0);
    tick();
    check("t1_oe_lat", {31'h0, AD_oe}, 32'h1);
    e = exp_q.pop_front();
    check("t1_data", {16'h0, AD_out}, {16'h0, e});
    rd_end("t1");
    wait_req(1'b1, "t1_req2");
    check("t1_addr_inc", {8'h0, mem_addr}, 32'h123457);
    repeat (8) tick();
    CS_N = 1'b1;
    repeat (10) tick();

    // burst of four reads, addr-derived data, 2-cycle memory
    mem_xor = 1'b1;
    mem_lat = 2;
    cs_start(8'h12, 16'h3456);
    repeat (12) tick();
    for (int i = 0; i < 4; i++) begin
      a16 = 16'h3456 + 16'(i);
      rd_begin($sformatf("t2_rd%0d", i), a16 ^ 16'hA5A5);
      tick(); tick();
      rd_end($sformatf("t2_rd%0d", i));
      repeat (6) tick();
    end
    check("t2_underrun", {31'h0, underrun}, 32'h0);
    CS_N = 1'b1;
    repeat (10) tick();

    // address wrap at all-ones
    cs_start(8'hFF, 16'hFFFF);
    repeat (12) tick();
    rd_begin("t3_rd0", 16'hFFFF ^ 16'hA5A5);
    tick();
    rd_end("t3_rd0");
    wait_req(1'b1, "t3_req");
    check("t3_wrap_addr", {8'h0, mem_addr}, 32'h000000);
    repeat (6) tick();
    rd_begin("t3_rd1", 16'h0000 ^ 16'hA5A5);
    tick();
    rd_end("t3_rd1");
    repeat (10) tick();
    CS_N = 1'b1;
    repeat (10) tick();

    // underrun: RD falls while a slow fetch is pending; stale = data of 0x000001
    mem_lat = 20;
    cs_start(8'h00, 16'h0200);
    wait_req(1'b1, "t4_req");
    tick(); tick();
    rd_begin("t4_stale", 16'h0001 ^ 16'hA5A5);
    check("t4_underrun", {31'h0, underrun}, 32'h1);
    check("t4_still_req", {31'h0, mem_req}, 32'h1);
    wait_ack("t4_ack");
    check("t4_fresh_data", {16'h0, AD_out}, {16'h0, 16'h0200 ^ 16'hA5A5});
    check("t4_oe_held", {31'h0, AD_oe}, 32'h1);
    mem_lat = 2;
    rd_end("t4");
    repeat (10) tick();
    CS_N = 1'b1;
    repeat (6) tick();
    check("t4_underrun_sticky", {31'h0, underrun}, 32'h1);
    repeat (4) tick();

    // CS released mid-fetch; new CS waits for the old ack before requesting
    mem_lat = 20;
    cs_start(8'h00, 16'h0300);
    wait_req(1'b1, "t5_req_old");
    check("t5_addr_old", {8'h0, mem_addr}, 32'h000300);
    tick(); tick();
    CS_N = 1'b1;
    repeat (5) tick();
    check("t5_oe_off", {31'h0, AD_oe}, 32'h0);
    check("t5_req_held", {31'h0, mem_req}, 32'h1);
    cs_start(8'h00, 16'h0100);
    repeat (6) tick();
    check("t5_addr_wait", {8'h0, mem_addr}, 32'h000300);
    wait_ack("t5_old_ack");
    mem_lat = 2;
    wait_req(1'b0, "t5_req_gap");
    wait_req(1'b1, "t5_req_new");
    check("t5_addr_new", {8'h0, mem_addr}, 32'h000100);
    repeat (6) tick();
    rd_begin("t5_rd", 16'h0100 ^ 16'hA5A5);
    rd_end("t5");
    repeat (6) tick();

    // reset while driving
    rd_begin("t6_rd", 16'h0101 ^ 16'hA5A5);
    RST_N = 1'b0;
    #1;
    check("t6_oe_async", {31'h0, AD_oe}, 32'h0);
    @(posedge CLK); #1;
    check_reset_outputs("t6_rst");
    RD_N  = 1'b1;
    CS_N  = 1'b1;
    RST_N = 1'b1;
    repeat (6) tick();
    check("t6_oe_idle", {31'h0, AD_oe}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
